// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for key-event consumers on the DE10-Lite design:
// state encodings, 20 MHz timing constants and the event-pulse bundle.
package key_event_decoder_pkg;

    // System clock and the default press timing derived from it.
    localparam int unsigned KEY_CLK_HZ            = 32'd20_000_000;
    localparam int unsigned KEY_LONG_CYCLES       = 32'd20_000_000; // 1 s
    localparam int unsigned KEY_REPEAT_CYCLES     = 32'd4_000_000;  // 200 ms
    localparam int unsigned KEY_CNT_W             = 32'd25;

    // Decoder states. All four 2-bit codes are assigned; the decoder still
    // routes any unexpected value back to KEY_WAIT_REL.
    typedef enum logic [1:0] {
        KEY_WAIT_REL = 2'd0,  // wait for a clean release before accepting presses
        KEY_IDLE     = 2'd1,  // released, waiting for a press
        KEY_PRESSED  = 2'd2,  // pressed, below the long threshold
        KEY_HELD     = 2'd3   // pressed past the long threshold, auto-repeating
    } key_state_e;

    // One-cycle event pulses produced by the decoder.
    typedef struct packed {
        logic press;
        logic rel;
        logic short_rel;
        logic long_hold;
        logic rpt;
    } key_events_t;

    // Map the raw key level onto "pressed", honouring the board polarity.
    function automatic logic key_is_pressed(input logic level, input logic active_low);
        key_is_pressed = active_low ? ~level : level;
    endfunction

    // Largest of two cycle counts; sizes the hold-counter terminal value.
    function automatic int unsigned key_max_cycles(input int unsigned a, input int unsigned b);
        key_max_cycles = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_event_decoder.sv
// Key event decoder: turns a debounced key level into single-cycle press,
// release, short, long and auto-repeat events plus a wrapping press counter.
// A key already held when reset is released is ignored until it is let go.
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned CNT_W         = KEY_CNT_W,
    parameter int unsigned LONG_CYCLES   = KEY_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = KEY_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       key_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       key_held,
    output logic [7:0] press_count
);

    // Terminal counts: the counter runs 0 .. N-1 and is cleared when it hits
    // the terminal value, so it can never exceed max(LONG, REPEAT)-1.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);

    logic             pressed_s;

    key_state_e       state_q;
    key_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    key_events_t      evt_q;
    key_events_t      evt_d;
    logic             held_q;
    logic             held_d;
    logic [7:0]       count_q;
    logic [7:0]       count_d;

    assign pressed_s = key_is_pressed(key_in, ACTIVE_LOW);

    // Next-state, counter and event decode for the key FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = '0;
        held_d  = 1'b0;
        count_d = count_q;

        case (state_q)
            KEY_WAIT_REL: begin
                cnt_d = '0;
                if (!pressed_s) begin
                    state_d = KEY_IDLE;
                end else begin
                    state_d = KEY_WAIT_REL;
                end
            end

            KEY_IDLE: begin
                cnt_d = '0;
                if (pressed_s) begin
                    state_d     = KEY_PRESSED;
                    evt_d.press = 1'b1;
                    held_d      = 1'b1;
                    count_d     = count_q + 8'd1;
                end else begin
                    state_d = KEY_IDLE;
                end
            end

            KEY_PRESSED: begin
                // key_held stays high through the release cycle itself.
                held_d = 1'b1;
                if (!pressed_s) begin
                    // Release wins over a coincident long threshold.
                    state_d         = KEY_IDLE;
                    evt_d.rel       = 1'b1;
                    evt_d.short_rel = 1'b1;
                    cnt_d           = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d         = KEY_HELD;
                    evt_d.long_hold = 1'b1;
                    cnt_d           = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            KEY_HELD: begin
                held_d = 1'b1;
                if (!pressed_s) begin
                    // Release wins over a coincident repeat tick.
                    state_d   = KEY_IDLE;
                    evt_d.rel = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    // Wrap even with repeat disabled so the counter never overflows.
                    evt_d.rpt = REPEAT_EN;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = KEY_WAIT_REL;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and hold counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= KEY_WAIT_REL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered event pulses and key_held level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            evt_q  <= '0;
            held_q <= 1'b0;
        end else begin
            evt_q  <= evt_d;
            held_q <= held_d;
        end
    end

    // Wrapping count of accepted presses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign press_pulse   = evt_q.press;
    assign release_pulse = evt_q.rel;
    assign short_pulse   = evt_q.short_rel;
    assign long_pulse    = evt_q.long_hold;
    assign repeat_pulse  = evt_q.rpt;
    assign key_held      = held_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder with short timing constants.
// Expected per-cycle outputs are derived from press length and pushed to a
// scoreboard queue as stimulus is driven; observations are compared in order.
module tb_key_event_decoder;

    localparam int LONG = 8;
    localparam int REP  = 4;

    typedef struct packed {
        logic       press;
        logic       rel;
        logic       short_p;
        logic       long_p;
        logic       rpt;
        logic       held;
        logic [7:0] count;
    } obs_t;

    logic       clk;
    logic       n_rst;
    logic       key_in;
    logic       press_pulse;
    logic       release_pulse;
    logic       short_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       key_held;
    logic [7:0] press_count;

    int         checks;
    int         errors;
    logic [7:0] exp_count;
    obs_t       exp_q[$];
    obs_t       obs_q[$];

    key_event_decoder #(
        .ACTIVE_LOW    (1'b1),
        .CNT_W         (8),
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP),
        .REPEAT_EN     (1'b1)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .key_in        (key_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .key_held      (key_held),
        .press_count   (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.press   = press_pulse;
        o.rel     = release_pulse;
        o.short_p = short_pulse;
        o.long_p  = long_pulse;
        o.rpt     = repeat_pulse;
        o.held    = key_held;
        o.count   = press_count;
        return o;
    endfunction

    function automatic obs_t quiet();
        obs_t o;
        o       = '0;
        o.count = exp_count;
        return o;
    endfunction

    // One clock: drive the key level, record the expectation, sample after the edge.
    task automatic drive_cycle(input logic key, input obs_t exp);
        key_in = key;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        obs_q.push_back(sample());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, quiet());
    endtask

    // A press of 'hold' clocks starting from IDLE; release optional.
    task automatic press_seq(input int hold, input bit do_release);
        obs_t e;
        for (int k = 0; k <= hold; k++) begin
            if (k == hold && !do_release) break;
            if (k == 0) exp_count = exp_count + 8'd1;
            e         = '0;
            e.press   = (k == 0);
            e.long_p  = (k == LONG) && (k < hold);
            e.rpt     = (k > LONG) && (k < hold) && (((k - LONG) % REP) == 0);
            e.rel     = (k == hold);
            e.short_p = (k == hold) && (hold <= LONG);
            e.held    = 1'b1;
            e.count   = exp_count;
            drive_cycle((k < hold) ? 1'b0 : 1'b1, e);
        end
    endtask

    task automatic do_reset(input logic key);
        n_rst  = 1'b0;
        key_in = key;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst     = 1'b1;
        exp_count = 8'd0;
    endtask

    task automatic test_reset();
        n_rst  = 1'b0;
        key_in = 1'b1;
        exp_count = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sample() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_state: got %b required %b", sample(), obs_t'(0));
        end
        @(negedge clk);
        n_rst = 1'b1;
        idle_cycles(3);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_idle: got %b required %b", o, e);
            end
        end
    endtask

    task automatic test_short_press();
        do_reset(1'b1);
        idle_cycles(9);
        press_seq(3, 1'b1);
        idle_cycles(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL short_press[%0d]: got %b required %b", i, o, e);
            end
        end
    endtask

    task automatic test_long_repeat();
        do_reset(1'b1);
        idle_cycles(9);
        press_seq(20, 1'b1);
        idle_cycles(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL long_repeat[%0d]: got %b required %b", i, o, e);
            end
        end
    endtask

    task automatic test_held_through_reset();
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, quiet());
        idle_cycles(1);
        press_seq(3, 1'b1);
        idle_cycles(1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL held_through_reset[%0d]: got %b required %b", i, o, e);
            end
        end
    endtask

    task automatic test_release_on_long();
        do_reset(1'b1);
        idle_cycles(2);
        press_seq(LONG, 1'b1);
        idle_cycles(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL release_on_long[%0d]: got %b required %b", i, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        idle_cycles(1);
        press_seq(2, 1'b1);
        press_seq(5, 1'b1);
        press_seq(9, 1'b1);
        press_seq(1, 1'b1);
        idle_cycles(1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b required %b", i, o, e);
            end
        end
    endtask

    task automatic test_count_wrap();
        int n_press;
        int n_rel;
        n_press = 0;
        n_rel   = 0;
        do_reset(1'b1);
        idle_cycles(1);
        for (int p = 0; p < 256; p++) begin
            press_seq(2, 1'b1);
            idle_cycles(1);
        end
        foreach (obs_q[i]) begin
            n_press += int'(obs_q[i].press);
            n_rel   += int'(obs_q[i].rel);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL count_wrap[%0d]: got %b required %b", i, o, e);
            end
        end
        checks++;
        if (n_press != 256) begin
            errors++;
            $display("FAIL count_wrap_presses: got %0d required 256", n_press);
        end
        checks++;
        if (n_rel != 256) begin
            errors++;
            $display("FAIL count_wrap_releases: got %0d required 256", n_rel);
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL count_wrap_final: got %0d required 0", press_count);
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        do_reset(1'b1);
        idle_cycles(1);
        press_seq(14, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            obs_t e = exp_q.pop_front();
            obs_t g = obs_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL async_reset_pre[%0d]: got %b required %b", i, g, e);
            end
        end
        // Between edges: pull reset and look before any clock edge arrives.
        #2;
        n_rst = 1'b0;
        #1;
        o = sample();
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("FAIL async_reset_clear: got %b required %b", o, obs_t'(0));
        end
        @(negedge clk);
        n_rst     = 1'b1;
        exp_count = 8'd0;
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, quiet());
        idle_cycles(1);
        press_seq(3, 1'b1);
        idle_cycles(1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            obs_t e = exp_q.pop_front();
            obs_t g = obs_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL async_reset_post[%0d]: got %b required %b", i, g, e);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = 8'd0;
        n_rst     = 1'b0;
        key_in    = 1'b1;
        test_reset();
        test_short_press();
        test_long_repeat();
        test_held_through_reset();
        test_release_on_long();
        test_back_to_back();
        test_count_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
